// File: rtl/alu_stager_pkg.sv
// alu_stager_pkg: shared types and derived sizes for the AND-reduction operand stager.
package alu_stager_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_BYTE_W = 8;
    localparam int DEF_SETTLE = 1;

    // Two operands, each DATA_W wide, delivered BYTE_W bits per beat.
    function automatic int beats_of(input int data_w, input int byte_w);
        return 2 * data_w / byte_w;
    endfunction

    localparam int BEATS     = beats_of(DEF_DATA_W, DEF_BYTE_W);
    localparam int BEAT_CW   = $clog2(BEATS);
    localparam int SETTLE_CW = $clog2(DEF_SETTLE + 1);

    typedef enum logic [1:0] {LOAD, EVAL, RESP} state_t;

endpackage

// File: rtl/alu_operand_stager_if.sv
// alu_operand_stager_if: byte-stream input, reducer operand/result and response bus.
// Optional ALU_STAGER_PARITY_EN adds in_par (even parity per beat) and par_err.
interface alu_operand_stager_if
    import alu_stager_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int BYTE_W = DEF_BYTE_W
);

    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              red_y;
    logic              res_y;
    logic              res_valid;
    logic              res_ready;
    logic              busy;
`ifdef ALU_STAGER_PARITY_EN
    logic              in_par;
    logic              par_err;
`endif

    modport slave (
        input  in_data, in_valid, red_y, res_ready,
`ifdef ALU_STAGER_PARITY_EN
        input  in_par,
        output par_err,
`endif
        output in_ready, op_a, op_b, res_y, res_valid, busy
    );

    modport master (
        output in_data, in_valid, red_y, res_ready,
`ifdef ALU_STAGER_PARITY_EN
        output in_par,
        input  par_err,
`endif
        input  in_ready, op_a, op_b, res_y, res_valid, busy
    );

endinterface

// File: rtl/alu_stager_cnt.sv
// alu_stager_cnt: loadable up-counter with synchronous clear and terminal-count flag.
module alu_stager_cnt #(
    parameter int W  = 2,
    parameter int TC = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    // Clear wins over load, load wins over count.
    always_comb begin
        cnt_d = clr ? '0 : ld ? ld_val : en ? cnt_q + W'(1) : cnt_q;
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
    assign tc  = cnt_q == W'(TC);

endmodule

// File: rtl/alu_operand_stager.sv
// alu_operand_stager: assembles operand bytes, lets the reducer settle, returns its result.
// Optional ALU_STAGER_PARITY_EN checks even parity per beat and zeroes res_y on error.
module alu_operand_stager
    import alu_stager_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int BYTE_W = DEF_BYTE_W,
    parameter int SETTLE = DEF_SETTLE
) (
    input logic                 clk,
    input logic                 rst,
    alu_operand_stager_if.slave bus
);

    localparam int NB  = beats_of(DATA_W, BYTE_W);
    localparam int BCW = NB > 1 ? $clog2(NB) : 1;
    localparam int SCW = $clog2(SETTLE + 1);

    state_t              state_q, state_d;
    logic [2*DATA_W-1:0] ops_q, ops_d;
    logic                res_y_q, res_y_d;
    logic                res_valid_q, res_valid_d;
    logic [BCW-1:0]      beat_cnt;
    logic                beat_tc;
    logic [SCW-1:0]      settle_cnt_unused;
    logic                settle_tc;
    logic                in_rdy, accept, last_beat, sample, handshake, force_zero;

    assign in_rdy    = state_q == LOAD && !rst;
    assign accept    = bus.in_valid && in_rdy;
    assign last_beat = accept && beat_tc;
    // EVAL runs SETTLE+1 cycles: operands stable for SETTLE full cycles, then red_y is captured.
    assign sample    = state_q == EVAL && settle_tc;
    assign handshake = state_q == RESP && res_valid_q && bus.res_ready;

    alu_stager_cnt #(.W(BCW), .TC(NB - 1)) u_beat_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (last_beat),
        .en     (accept),
        .ld     (1'b0),
        .ld_val ('0),
        .cnt    (beat_cnt),
        .tc     (beat_tc)
    );

    alu_stager_cnt #(.W(SCW), .TC(SETTLE)) u_settle_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (sample),
        .en     (state_q == EVAL),
        .ld     (1'b0),
        .ld_val ('0),
        .cnt    (settle_cnt_unused),
        .tc     (settle_tc)
    );

`ifdef ALU_STAGER_PARITY_EN
    logic par_err_q, par_err_d;

    // Sticky parity error for the current transaction, cleared by the result handshake.
    always_comb begin
        par_err_d = handshake ? 1'b0 : (accept && bus.in_par != ^bus.in_data) ? 1'b1 : par_err_q;
    end

    // Parity error register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) par_err_q <= 1'b0;
        else     par_err_q <= par_err_d;
    end

    assign force_zero  = par_err_q;
    assign bus.par_err = par_err_q;
`else
    assign force_zero = 1'b0;
`endif

    // Next-state: byte slot write, phase sequencing, result capture and release.
    always_comb begin
        ops_d = ops_q;
        if (accept) ops_d[int'(beat_cnt) * BYTE_W +: BYTE_W] = bus.in_data;
        state_d     = last_beat ? EVAL : sample ? RESP : handshake ? LOAD : state_q;
        res_y_d     = sample ? bus.red_y && !force_zero : res_y_q;
        res_valid_d = sample ? 1'b1 : handshake ? 1'b0 : res_valid_q;
    end

    // State, operand and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            ops_q       <= '0;
            res_y_q     <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ops_q       <= ops_d;
            res_y_q     <= res_y_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.op_a      = ops_q[DATA_W-1:0];
    assign bus.op_b      = ops_q[2*DATA_W-1:DATA_W];
    assign bus.res_y     = res_y_q;
    assign bus.res_valid = res_valid_q;
    assign bus.busy      = state_q != LOAD || beat_cnt != '0;

endmodule

// File: tb/tb_alu_operand_stager.sv
// tb_alu_operand_stager: table-driven, hand-written and randomized checks of the operand stager.
module tb_alu_operand_stager;

    localparam int SETTLE = 1;

    typedef struct {
        logic [31:0] bytes;
        int          gap_after;
        int          gap_len;
        int          rdy_delay;
        logic [3:0]  badpar;
        logic [15:0] ea;
        logic [15:0] eb;
        logic        ey;
        string       tag;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    alu_operand_stager_if #(.DATA_W(16), .BYTE_W(8)) bus ();

    alu_operand_stager #(.DATA_W(16), .BYTE_W(8), .SETTLE(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.red_y = &(bus.op_a & bus.op_b);

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s got %0h want %0h", name, got, exp);
        else pass_cnt++;
    endtask

    task automatic run_txn(input vec_t v);
        int lat;
        bus.res_ready = v.rdy_delay == 0;
        for (int k = 0; k < 4; k++) begin
            if (k == v.gap_after) begin
                bus.in_valid = 1'b0;
                for (int g = 0; g < v.gap_len; g++) begin
                    bus.in_data = 8'($urandom);
                    @(negedge clk);
                    chk({v.tag, ".gap_ready"}, bus.in_ready, 1);
                end
            end
            bus.in_data  = v.bytes[k*8 +: 8];
            bus.in_valid = 1'b1;
`ifdef ALU_STAGER_PARITY_EN
            bus.in_par = ^v.bytes[k*8 +: 8] ^ v.badpar[k];
`endif
            @(negedge clk);
        end
        bus.in_valid = v.rdy_delay > 0;
        bus.in_data  = 8'($urandom);
        lat = 0;
        while (!bus.res_valid && lat < 20) begin
            chk({v.tag, ".eval_ready"}, bus.in_ready, 0);
            @(negedge clk);
            lat++;
        end
        chk({v.tag, ".latency"}, lat, SETTLE + 1);
        chk({v.tag, ".res_y"}, bus.res_y, v.ey);
        chk({v.tag, ".op_a"}, bus.op_a, v.ea);
        chk({v.tag, ".op_b"}, bus.op_b, v.eb);
        chk({v.tag, ".busy"}, bus.busy, 1);
`ifdef ALU_STAGER_PARITY_EN
        chk({v.tag, ".par_err"}, bus.par_err, v.badpar != 0);
`endif
        for (int h = 0; h < v.rdy_delay; h++) begin
            bus.in_data = 8'($urandom);
            @(negedge clk);
            chk({v.tag, ".hold_valid"}, bus.res_valid, 1);
            chk({v.tag, ".hold_y"}, bus.res_y, v.ey);
            chk({v.tag, ".hold_a"}, bus.op_a, v.ea);
            chk({v.tag, ".hold_b"}, bus.op_b, v.eb);
            chk({v.tag, ".hold_ready"}, bus.in_ready, 0);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk({v.tag, ".post_valid"}, bus.res_valid, 0);
        chk({v.tag, ".post_busy"}, bus.busy, 0);
        chk({v.tag, ".post_ready"}, bus.in_ready, 1);
`ifdef ALU_STAGER_PARITY_EN
        chk({v.tag, ".post_par_err"}, bus.par_err, 0);
`endif
    endtask

    initial begin
        vec_t        tbl[$];
        vec_t        v;
        logic [15:0] a, b;
        tbl.push_back('{32'hFFFFFFFF, 9, 0, 0, 4'b0000, 16'hFFFF, 16'hFFFF, 1'b1, "ones"});
        tbl.push_back('{32'hFFFEFFFF, 2, 3, 0, 4'b0000, 16'hFFFF, 16'hFFFE, 1'b0, "bubble"});
        tbl.push_back('{32'h0F0FA5C3, 9, 0, 5, 4'b0000, 16'hA5C3, 16'h0F0F, 1'b0, "stall0"});
        tbl.push_back('{32'hFFFFFFFF, 1, 1, 5, 4'b0000, 16'hFFFF, 16'hFFFF, 1'b1, "stall1"});
`ifdef ALU_STAGER_PARITY_EN
        tbl.push_back('{32'hFFFFFFFF, 9, 0, 0, 4'b0100, 16'hFFFF, 16'hFFFF, 1'b0, "par_bad"});
        tbl.push_back('{32'hFFFFFFFF, 9, 0, 0, 4'b0000, 16'hFFFF, 16'hFFFF, 1'b1, "par_clean"});
`endif
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b0;
`ifdef ALU_STAGER_PARITY_EN
        bus.in_par = 1'b0;
`endif
        #2 rst = 1'b1;
        #1;
        chk("rst.op_a", bus.op_a, 0);
        chk("rst.op_b", bus.op_b, 0);
        chk("rst.res_y", bus.res_y, 0);
        chk("rst.res_valid", bus.res_valid, 0);
        chk("rst.busy", bus.busy, 0);
        chk("rst.in_ready", bus.in_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel.in_ready", bus.in_ready, 1);
        chk("rel.busy", bus.busy, 0);
        chk("rel.res_valid", bus.res_valid, 0);

        foreach (tbl[i]) run_txn(tbl[i]);

        bus.in_valid = 1'b1;
        bus.in_data  = 8'h34;
        @(negedge clk);
        bus.in_data = 8'h12;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("mid.op_a", bus.op_a, 16'h1234);
        chk("mid.busy", bus.busy, 1);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst.op_a", bus.op_a, 0);
        chk("mid_rst.busy", bus.busy, 0);
        chk("mid_rst.res_valid", bus.res_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rel.in_ready", bus.in_ready, 1);
        chk("mid_rel.busy", bus.busy, 0);
        v = '{32'h00010001, 9, 0, 0, 4'b0000, 16'h0001, 16'h0001, 1'b0, "after_rst"};
        run_txn(v);

        for (int r = 0; r < 30; r++) begin
            for (int k = 0; k < 4; k++)
                v.bytes[k*8 +: 8] = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'hFF;
            v.gap_after = $urandom_range(0, 5);
            v.gap_len   = $urandom_range(1, 3);
            v.rdy_delay = $urandom_range(0, 3);
            v.badpar    = 4'b0000;
`ifdef ALU_STAGER_PARITY_EN
            if ($urandom_range(0, 7) == 0) v.badpar = 4'($urandom_range(1, 15));
`endif
            a    = v.bytes[15:0];
            b    = v.bytes[31:16];
            v.ea = a;
            v.eb = b;
            v.ey = (a & b) == 16'hFFFF && v.badpar == 0;
            v.tag = $sformatf("rnd%0d", r);
            run_txn(v);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
